// File: rtl/jk_pkg.sv
// jk_pkg: shared FSM state type and JK excitation codes for the drive generator.
package jk_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN} state_t;
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;
  function automatic logic [1:0] jk_code(input logic t, input logic q, input logic dc);
    return (t == q) ? JK_HOLD : dc ? JK_TOGGLE : t ? JK_SET : JK_RESET;
  endfunction
endpackage

// File: rtl/jk_bit_fifo.sv
// jk_bit_fifo: single-bit FIFO with registered storage, so a pushed bit is visible only after its write edge.
module jk_bit_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   din,
  output logic                   dout,
  output logic                   ready,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [DEPTH-1:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign ready   = level != LW'(DEPTH);
  assign do_push = push & ready;
  assign do_pop  = pop & (level != '0);
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
endmodule

// File: rtl/jk_drive_gen.sv
// jk_drive_gen: turns a stream of target bits into JK excitations and checks the driven flip-flop one cycle later.
module jk_drive_gen
  import jk_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter bit DC_MODE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_bit,
  output logic                   in_ready,
  input  logic                   q_fb,
  input  logic                   clr,
  output logic                   j,
  output logic                   k,
  output logic                   drv_valid,
  output logic                   exp_q,
  output logic                   mismatch,
  output logic [7:0]             err_count,
  output logic [$clog2(DEPTH):0] level
);
  localparam int LW = $clog2(DEPTH) + 1;
  state_t state, next;
  logic head, pend;
  jk_bit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(in_valid), .pop(drv_valid), .din(in_bit),
    .dout(head), .ready(in_ready), .level(level)
  );
  assign drv_valid = state == DRIVE;
  assign {j, k} = drv_valid ? jk_code(head, exp_q, DC_MODE) : JK_HOLD;
  always_comb begin
    next = state;
    next = (state == IDLE)  ? ((level != '0) ? DRIVE : IDLE) :
           (state == DRIVE) ? ((level > LW'(1) || (in_valid && in_ready)) ? DRIVE : DRAIN) :
                              ((level != '0) ? DRIVE : IDLE);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  // pend marks the cycle where q_fb reflects the previous drive
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      exp_q     <= 1'b0;
      pend      <= 1'b0;
      mismatch  <= 1'b0;
      err_count <= '0;
    end else begin
      pend <= drv_valid;
      if (drv_valid) exp_q <= head;
      if (clr) begin
        mismatch  <= 1'b0;
        err_count <= '0;
      end else if (pend && q_fb != exp_q) begin
        mismatch  <= 1'b1;
        err_count <= err_count + 8'(err_count != 8'hff);
      end
    end
endmodule

// File: tb/tb_jk_drive_gen.sv
// tb_jk_drive_gen: drives both don't-care modes in lockstep against JK flip-flop models, plus a standalone FIFO.
module tb_jk_drive_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0, in_valid = 1'b0, in_bit = 1'b0, clr = 1'b0;
  logic force_en = 1'b0, force_val = 1'b0;
  logic j0, k0, dv0, eq0, mm0, rdy0, j1, k1, dv1, eq1, mm1, rdy1;
  logic [7:0] ec0, ec1;
  logic [2:0] lv0, lv1;
  logic q0, q1, ff_rst, q_fb0;
  logic f_push = 1'b0, f_pop = 1'b0, f_din = 1'b0, f_dout, f_ready;
  logic [2:0] f_level;
  int n_cmp = 0, n_bad = 0;
  logic [1:0] sb0[$], sb1[$];
  logic tq[$], fq[$];
  logic m = 1'b0;
  logic [1:0] e0, e1;
  logic pend_v = 1'b0, pend_t = 1'b0;

  jk_drive_gen #(.DEPTH(4), .DC_MODE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(rdy0),
    .q_fb(q_fb0), .clr(clr), .j(j0), .k(k0), .drv_valid(dv0), .exp_q(eq0),
    .mismatch(mm0), .err_count(ec0), .level(lv0));
  jk_drive_gen #(.DEPTH(4), .DC_MODE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(rdy1),
    .q_fb(q1), .clr(clr), .j(j1), .k(k1), .drv_valid(dv1), .exp_q(eq1),
    .mismatch(mm1), .err_count(ec1), .level(lv1));
  jk_bit_fifo #(.DEPTH(4)) u_fifo (
    .clk(clk), .rst(rst), .push(f_push), .pop(f_pop), .din(f_din),
    .dout(f_dout), .ready(f_ready), .level(f_level));

  assign ff_rst = ~rst;
  assign q_fb0 = force_en ? force_val : q0;
  always_ff @(posedge clk or posedge ff_rst)
    if (ff_rst) q0 <= 1'b0;
    else q0 <= (j0 & k0) ? ~q0 : j0 ? 1'b1 : k0 ? 1'b0 : q0;
  always_ff @(posedge clk or posedge ff_rst)
    if (ff_rst) q1 <= 1'b0;
    else q1 <= (j1 & k1) ? ~q1 : j1 ? 1'b1 : k1 ? 1'b0 : q1;

  function automatic logic [1:0] exp_jk(input logic t, input logic q, input bit dc);
    if (t == q) return 2'b00;
    if (dc) return 2'b11;
    return t ? 2'b10 : 2'b01;
  endfunction

  // scoreboard: pops an expected excitation whenever a drive cycle is observed
  always @(negedge clk) begin
    if (!rst) pend_v = 1'b0;
    else begin
      if (pend_v) begin
        n_cmp++;
        if (q0 !== pend_t || q1 !== pend_t) begin
          n_bad++;
          $display("FAIL ff_q got %b/%b want %b", q0, q1, pend_t);
        end
      end
      pend_v = dv0;
      if (dv0) pend_t = tq.size() ? tq.pop_front() : 1'bx;
      e0 = dv0 ? (sb0.size() ? sb0.pop_front() : 2'bxx) : 2'b00;
      n_cmp++;
      if ({j0, k0} !== e0) begin
        n_bad++;
        $display("FAIL jk_dc0 got %b want %b (drv_valid %b)", {j0, k0}, e0, dv0);
      end
      e1 = dv1 ? (sb1.size() ? sb1.pop_front() : 2'bxx) : 2'b00;
      n_cmp++;
      if ({dv1, j1, k1} !== {dv0, e1}) begin
        n_bad++;
        $display("FAIL jk_dc1 got %b want %b", {dv1, j1, k1}, {dv0, e1});
      end
    end
  end

  task automatic push_bit(input logic b);
    @(negedge clk);
    in_valid = 1'b1;
    in_bit = b;
    if (rdy0) begin
      sb0.push_back(exp_jk(b, m, 1'b0));
      sb1.push_back(exp_jk(b, m, 1'b1));
      tq.push_back(b);
      m = b;
    end
  endtask

  task automatic settle();
    int w;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while ((sb0.size() != 0 || dv0 || dv1 || lv0 != 0) && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    n_cmp++;
    if (w >= 50) begin
      n_bad++;
      $display("FAIL settle_timeout got %0d cycles want <50", w);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({lv0, rdy0, j0, k0, dv0, eq0, mm0, ec0} !== {3'd0, 1'b1, 13'd0}) begin
      n_bad++;
      $display("FAIL reset_dc0 got %b want %b", {lv0, rdy0, j0, k0, dv0, eq0, mm0, ec0}, {3'd0, 1'b1, 13'd0});
    end
    n_cmp++;
    if ({lv1, rdy1, j1, k1, dv1, eq1, mm1, ec1} !== {3'd0, 1'b1, 13'd0}) begin
      n_bad++;
      $display("FAIL reset_dc1 got %b want %b", {lv1, rdy1, j1, k1, dv1, eq1, mm1, ec1}, {3'd0, 1'b1, 13'd0});
    end
    rst = 1'b1;
  endtask

  task automatic test_dc_modes();
    push_bit(1'b1); push_bit(1'b0); push_bit(1'b0); push_bit(1'b1);
    settle();
    n_cmp++;
    if ({eq0, mm0, q0, eq1, mm1, q1} !== 6'b101101) begin
      n_bad++;
      $display("FAIL stream_end got %b want 101101", {eq0, mm0, q0, eq1, mm1, q1});
    end
  endtask

  task automatic test_errors();
    force_en = 1'b1;
    force_val = 1'b0;
    push_bit(1'b1); push_bit(1'b1); push_bit(1'b1);
    settle();
    force_en = 1'b0;
    n_cmp++;
    if ({mm0, ec0, mm1} !== {1'b1, 8'd3, 1'b0}) begin
      n_bad++;
      $display("FAIL err_three got mm=%b cnt=%0d mm1=%b want 1/3/0", mm0, ec0, mm1);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_cmp++;
    if ({mm0, ec0} !== 9'd0) begin
      n_bad++;
      $display("FAIL clr got mm=%b cnt=%0d want 0/0", mm0, ec0);
    end
  endtask

  task automatic test_saturation();
    force_en = 1'b1;
    force_val = 1'b0;
    for (int i = 0; i < 300; i++) push_bit(1'b1);
    settle();
    force_en = 1'b0;
    n_cmp++;
    if ({mm0, ec0} !== {1'b1, 8'd255}) begin
      n_bad++;
      $display("FAIL saturate got mm=%b cnt=%0d want 1/255", mm0, ec0);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic [4:0] pat;
    logic e;
    pat = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (f_ready !== (i < 4)) begin
        n_bad++;
        $display("FAIL fifo_ready push%0d got %b want %b", i, f_ready, i < 4);
      end
      f_push = 1'b1;
      f_din = pat[i];
      if (f_ready) fq.push_back(pat[i]);
    end
    @(negedge clk);
    f_push = 1'b0;
    n_cmp++;
    if ({f_level, f_ready} !== {3'd4, 1'b0}) begin
      n_bad++;
      $display("FAIL fifo_full got level=%0d ready=%b want 4/0", f_level, f_ready);
    end
    f_pop = 1'b1;
    e = fq.pop_front();
    n_cmp++;
    if (f_dout !== e) begin
      n_bad++;
      $display("FAIL fifo_head got %b want %b", f_dout, e);
    end
    @(negedge clk);
    f_pop = 1'b0;
    f_push = 1'b1;
    f_din = pat[4];
    fq.push_back(pat[4]);
    @(negedge clk);
    f_push = 1'b0;
    n_cmp++;
    if (f_level !== 3'd4) begin
      n_bad++;
      $display("FAIL fifo_refill got %0d want 4", f_level);
    end
    for (int i = 0; i < 4; i++) begin
      e = fq.pop_front();
      n_cmp++;
      if (f_dout !== e) begin
        n_bad++;
        $display("FAIL fifo_order idx%0d got %b want %b", i, f_dout, e);
      end
      f_pop = 1'b1;
      @(negedge clk);
    end
    f_pop = 1'b0;
    n_cmp++;
    if (f_level !== 3'd0) begin
      n_bad++;
      $display("FAIL fifo_empty got %0d want 0", f_level);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      f_push = 1'b1;
      f_din = 1'b1;
    end
    @(negedge clk);
    f_push = 1'b0;
    n_cmp++;
    if (f_level !== 3'd3) begin
      n_bad++;
      $display("FAIL fifo_pre_reset got %0d want 3", f_level);
    end
    push_bit(1'b1); push_bit(1'b1); push_bit(1'b0); push_bit(1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({dv0, eq0, lv0 != 3'd0} !== 3'b111) begin
      n_bad++;
      $display("FAIL pre_reset got dv=%b exp_q=%b level=%0d want 1/1/>0", dv0, eq0, lv0);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({lv0, j0, k0, dv0, eq0, f_level, rdy0} !== {3'd0, 4'd0, 3'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL async_reset got lvl=%0d jk=%b dv=%b exp_q=%b flvl=%0d rdy=%b want 0/00/0/0/0/1",
               lv0, {j0, k0}, dv0, eq0, f_level, rdy0);
    end
    sb0.delete();
    sb1.delete();
    tq.delete();
    m = 1'b0;
    pend_v = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    push_bit(1'b0); push_bit(1'b1);
    settle();
    n_cmp++;
    if ({eq0, mm0, ec0, eq1, mm1} !== {1'b1, 9'd0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL resume got exp_q=%b mm=%b cnt=%0d exp_q1=%b mm1=%b want 1/0/0/1/0", eq0, mm0, ec0, eq1, mm1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dc_modes();
    test_errors();
    test_saturation();
    test_fifo_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/jk_drive_gen.md
JK_DRIVE_GEN -- requirements
Module: jk_drive_gen

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
  DEPTH  4  target-bit FIFO entries (power of 2, minimum 2)
  DC_MODE  0  excitation don't-care resolution (0 = hold/set/reset codes; 1 = toggle code for state changes)
REQ-002 Ports SHALL be as follows, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state on rising edge
  rst  in  1  asynchronous, active-low reset
  in_valid  in  1  target bit offered
  in_bit  in  1  desired next flip-flop state
  in_ready  out  1  FIFO can accept
  q_fb  in  1  observed q of the driven JK flip-flop
  clr  in  1  synchronous clear of error status
  j  out  1  J excitation to flip-flop
  k  out  1  K excitation to flip-flop
  drv_valid  out  1  j/k carry a popped target this cycle
  exp_q  out  1  model of flip-flop state
  mismatch  out  1  sticky compare-failure flag
  err_count  out  8  saturating mismatch count
  level  out  $clog2(DEPTH)+1  FIFO occupancy

Function
REQ-003 A push SHALL occur on a rising edge with in_valid=1 and in_ready=1; in_ready SHALL equal (level != DEPTH).
REQ-004 The FSM SHALL have states IDLE, DRIVE and DRAIN.
  IDLE: FIFO empty, no compare pending.
  DRIVE: one bit popped per cycle.
  DRAIN: final compare pending, FIFO empty.
REQ-005 Transitions SHALL be:
  IDLE->DRIVE when level>0.
  DRIVE stays DRIVE while level>1 or a push coincides.
  DRIVE->DRAIN when the last bit pops with no push.
  DRAIN->DRIVE if level>0, else DRAIN->IDLE.
REQ-006 In DRIVE, the head bit t SHALL pop each cycle with drv_valid=1, and {j,k} SHALL be combinationally derived from exp_q and t.
  DC_MODE=0: t==exp_q gives 00; t=1 gives 10; t=0 gives 01.
  DC_MODE=1: t==exp_q gives 00; t!=exp_q gives 11.
REQ-007 When drv_valid=0, {j,k} SHALL be 00 (hold).
REQ-008 exp_q SHALL take t on the edge ending a drive cycle.
REQ-009 q_fb SHALL be compared with exp_q in the cycle after each drive cycle, a 1-cycle flip-flop latency.
  On inequality: mismatch<=1 and err_count increments, saturating at 255.
REQ-010 A pushed bit SHALL first appear on j/k no earlier than the cycle after the push; there is no FIFO fall-through.
REQ-011 Push and pop SHALL be permitted in the same cycle; level is unchanged and the pointers wrap modulo DEPTH.
REQ-012 clr=1 SHALL zero mismatch and err_count; clr SHALL win over a coincident compare failure.
REQ-013 A push while full SHALL be ignored with no state change.

Reset
REQ-014 rst low SHALL asynchronously force the following, independent of clk:
  state=IDLE, level=0, pointers=0, exp_q=0, j=0, k=0, drv_valid=0, mismatch=0, err_count=0, in_ready=1.
REQ-015 Reset mid-stream SHALL discard FIFO contents and any pending compare.
REQ-016 Operation SHALL resume on the first clk edge after rst deasserts.

Structure
REQ-017 The state encoding typedef and the JK excitation codes (HOLD=00, RESET=01, SET=10, TOGGLE=11) SHALL reside in the shared package jk_pkg.
REQ-018 The FIFO SHALL be a sub-module named jk_bit_fifo, parameterised by DEPTH.

Verification
REQ-019 The bench SHALL instance jk_drive_gen driving a jk_ff whose reset is tied to the inverted rst, with q fed back to q_fb, and SHALL cover:
  - Reset then push 1,0,0,1 with DC_MODE=0 -> {j,k} = 10,01,00,10 on consecutive drive cycles; mismatch=0; exp_q=1 at end.
  - Same stream with DC_MODE=1 -> {j,k} = 11,11,00,11; q follows 1,0,0,1.
  - Push 5 bits back-to-back with DEPTH=4 and no drain -> in_ready=0 at level 4; the 5th bit is accepted only after a pop.
  - Force q_fb=0 while pushing 1,1,1 -> mismatch=1, err_count=3; assert clr -> both return to 0.
  - Assert rst mid-stream with level=3 -> level=0, j=k=0, exp_q=0 immediately, without waiting for a clk edge.
  - Hold q_fb wrong for 300 compares -> err_count saturates at 255.
